// File: rtl/scan_cfg_pkg.sv
// Shared types and sizing helpers for the scan-chain configuration loader.
package scan_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } state_t;

  function automatic int words_for(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

  // Bits taken from the final word of a session; a whole word when len divides evenly.
  function automatic int last_bits(input int len, input int w);
    return ((len % w) == 0) ? w : (len % w);
  endfunction

endpackage

// File: rtl/scan_piso.sv
// Parallel-in/serial-out word shifter, LSB first, with a count of bits still to send.
module scan_piso #(
  parameter int WORD_W = 32,
  parameter int REM_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [REM_W-1:0]  nbits,
  input  logic              shift,
  output logic              sbit,
  output logic [REM_W-1:0]  rem,
  output logic              empty,
  output logic              last
);

  logic [WORD_W-1:0] sreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (load) begin
      rem <= nbits;
    end else if (shift && !empty) begin
      rem <= rem - REM_W'(1);
    end
  end

  // A load landing on the last shift replaces the word with no idle cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= data;
    end else if (shift) begin
      sreg <= sreg >> 1;
    end
  end

  assign empty = (rem == '0);
  assign last  = (rem == REM_W'(1));
  assign sbit  = sreg[0] & ~empty;

endmodule

// File: rtl/scan_config_loader.sv
// Serializes host config words onto one SRL mux scan chain and reports completion.
// Optional macro SCAN_READBACK_EN adds capture of the previous chain contents on R_DATA/R_VALID.
module scan_config_loader
  import scan_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 992,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [WORD_W-1:0] S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic              SIN,
  output logic              CE,
  input  logic              SOUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  BIT_CNT
`ifdef SCAN_READBACK_EN
  ,
  output logic [WORD_W-1:0] R_DATA,
  output logic              R_VALID
`endif
);

  localparam int WORDS  = words_for(CHAIN_LEN, WORD_W);
  localparam int LAST_N = last_bits(CHAIN_LEN, WORD_W);
  localparam int REM_W  = $clog2(WORD_W + 1);
  localparam int WCNT_W = $clog2(WORDS + 1);

  state_t             state, state_nxt;
  logic [WCNT_W-1:0]  words_acc;
  logic               more_words;
  logic               accept;
  logic               session_start;
  logic               final_shift;
  logic [REM_W-1:0]   load_bits;
  logic               p_empty;
  logic               p_last;
  logic [REM_W-1:0]   unused_rem;

  assign more_words    = (words_acc != WCNT_W'(WORDS));
  assign accept        = S_VALID && S_READY;
  assign session_start = (state == IDLE) && START;
  assign final_shift   = CE && (BIT_CNT == CNT_W'(CHAIN_LEN - 1));
  assign load_bits     = (words_acc == WCNT_W'(WORDS - 1)) ? REM_W'(LAST_N) : REM_W'(WORD_W);

  scan_piso #(
    .WORD_W (WORD_W),
    .REM_W  (REM_W)
  ) u_piso (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (accept),
    .data  (S_DATA),
    .nbits (load_bits),
    .shift (CE),
    .sbit  (SIN),
    .rem   (unused_rem),
    .empty (p_empty),
    .last  (p_last)
  );

  // The shifter only holds bits during LOAD, so its occupancy is the chain enable.
  assign CE   = ~p_empty;
  assign BUSY = (state != IDLE);

  always_comb begin
    state_nxt = state;
    S_READY   = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = LOAD;
      end
      LOAD: begin
        S_READY = more_words && (p_empty || p_last);
        if (final_shift) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      words_acc <= '0;
      BIT_CNT   <= '0;
      DONE      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (session_start) begin
        words_acc <= '0;
        BIT_CNT   <= '0;
        DONE      <= 1'b0;
      end else begin
        if (accept) words_acc <= words_acc + WCNT_W'(1);
        if (CE && (BIT_CNT != CNT_W'(CHAIN_LEN))) BIT_CNT <= BIT_CNT + CNT_W'(1);
        if (state == FINISH) DONE <= 1'b1;
      end
    end
  end

`ifdef SCAN_READBACK_EN
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] cap, cap_nxt;
  logic [IDX_W-1:0]  cap_idx;

  always_comb begin
    cap_nxt          = cap;
    cap_nxt[cap_idx] = SOUT;
  end

  // SOUT shows the bit being pushed out of the chain, i.e. the previous configuration.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      R_DATA  <= '0;
      R_VALID <= 1'b0;
      cap     <= '0;
      cap_idx <= '0;
    end else begin
      R_VALID <= 1'b0;
      if (session_start) begin
        cap     <= '0;
        cap_idx <= '0;
      end else if (CE) begin
        if ((cap_idx == IDX_W'(WORD_W - 1)) || final_shift) begin
          R_DATA  <= cap_nxt;
          R_VALID <= 1'b1;
          cap     <= '0;
          cap_idx <= '0;
        end else begin
          cap     <= cap_nxt;
          cap_idx <= cap_idx + IDX_W'(1);
        end
      end
    end
  end
`else
  logic unused_sout;
  assign unused_sout = SOUT;
`endif

endmodule

// File: tb/tb_scan_config_loader.sv
// Scoreboard bench for scan_config_loader: a 70-bit chain instance plus a default-size instance.
module tb_scan_config_loader;

  localparam int LEN    = 70;
  localparam int W      = 32;
  localparam int CW     = $clog2(LEN + 1);
  localparam int BIG_CW = $clog2(992 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, s_valid, s_ready, sin, ce, sout, busy, done;
  logic [W-1:0]  s_data;
  logic [CW-1:0] bit_cnt;
`ifdef SCAN_READBACK_EN
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic [W-1:0]  b_rdata;
  logic          b_rvalid;
`endif

  logic              b_start, b_valid, b_ready, b_sin, b_ce, b_busy, b_done;
  logic [W-1:0]      b_data;
  logic [BIG_CW-1:0] b_bit_cnt;

  logic [LEN-1:0] chain = '0;
  assign sout = chain[0];
  always @(posedge clk) if (ce) chain <= {sin, chain[LEN-1:1]};

  scan_config_loader #(.CHAIN_LEN(LEN), .WORD_W(W)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .S_DATA(s_data), .S_VALID(s_valid),
    .S_READY(s_ready), .SIN(sin), .CE(ce), .SOUT(sout), .BUSY(busy), .DONE(done),
    .BIT_CNT(bit_cnt)
`ifdef SCAN_READBACK_EN
    , .R_DATA(r_data), .R_VALID(r_valid)
`endif
  );

  scan_config_loader dut_big (
    .CLK(clk), .RST_N(rst_n), .START(b_start), .S_DATA(b_data), .S_VALID(b_valid),
    .S_READY(b_ready), .SIN(b_sin), .CE(b_ce), .SOUT(1'b0), .BUSY(b_busy), .DONE(b_done),
    .BIT_CNT(b_bit_cnt)
`ifdef SCAN_READBACK_EN
    , .R_DATA(b_rdata), .R_VALID(b_rvalid)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  bit           exp_q[$], got_q[$], gap_sin_q[$], late_ready_q[$];
  int           gap_cnt_q[$];
  logic [W-1:0] rd_q[$];
  logic [W-1:0] pat[3];
  int  exp_bits, widx, ce_cnt, first_ce, last_ce, cyc, stall_left;
  bit  feed, stall_armed, done_s;

  function automatic logic [LEN-1:0] stream_of(input logic [W-1:0] a, b, c);
    logic [3*W-1:0] cat;
    cat = {c, b, a};
    return cat[LEN-1:0];
  endfunction

  // One clock: sample at negedge, then advance to 1 time unit past the rising edge.
  task automatic tick();
    @(negedge clk);
    done_s = done;
    if (ce) begin
      got_q.push_back(sin);
      if (ce_cnt == 0) first_ce = cyc;
      last_ce = cyc;
      ce_cnt++;
    end else if (busy && ce_cnt > 0 && ce_cnt < LEN) begin
      gap_cnt_q.push_back(int'(bit_cnt));
      gap_sin_q.push_back(sin);
    end
    if (busy && widx >= 3) late_ready_q.push_back(s_ready);
`ifdef SCAN_READBACK_EN
    if (r_valid) rd_q.push_back(r_data);
`endif
    if (s_valid && s_ready) begin
      for (int b = 0; b < W; b++) begin
        if (exp_bits < LEN) begin
          exp_q.push_back(s_data[b]);
          exp_bits++;
        end
      end
      widx++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (feed) begin
      if (stall_armed && widx == 1 && s_ready) begin
        stall_left  = 5;
        stall_armed = 1'b0;
      end
      if (stall_left > 0) begin
        s_valid = 1'b0;
        stall_left--;
      end else begin
        s_valid = 1'b1;
        s_data  = (widx < 3) ? pat[widx] : 32'hFFFF_FFFF;
      end
    end else begin
      s_valid = 1'b0;
    end
  endtask

  task automatic begin_session(input logic [W-1:0] p0, p1, p2, input bit stall);
    got_q.delete(); exp_q.delete(); gap_cnt_q.delete(); gap_sin_q.delete();
    late_ready_q.delete(); rd_q.delete();
    exp_bits = 0; widx = 0; ce_cnt = 0; first_ce = 0; last_ce = 0;
    stall_armed = stall; stall_left = 0; done_s = 1'b0;
    pat[0] = p0; pat[1] = p1; pat[2] = p2;
    feed = 1'b1; s_valid = 1'b1; s_data = p0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit, input int restart_at, output int n_done);
    n_done = -1;
    for (int n = 0; n < limit; n++) begin
      start = (n == restart_at);
      tick();
      if (done_s) begin
        n_done = n;
        break;
      end
    end
    start = 1'b0; feed = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", s_ready); end
    vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce got %b want 0", ce); end
    vectors++; if (sin !== 1'b0) begin miscompares++; $display("FAIL reset_sin got %b want 0", sin); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (bit_cnt !== '0) begin miscompares++; $display("FAIL reset_bitcnt got %0d want 0", bit_cnt); end
`ifdef SCAN_READBACK_EN
    vectors++; if (r_valid !== 1'b0 || r_data !== '0) begin miscompares++; $display("FAIL reset_rb got %b/%h want 0/0", r_valid, r_data); end
`endif
  endtask

  task automatic test_basic();
    int n_done, bad;
    begin_session(32'hA5C3_0F96, 32'h1234_5678, 32'hDEAD_BE2D, 1'b0);
    run_to_done(200, -1, n_done);
    vectors++; if (n_done !== 72) begin miscompares++; $display("FAIL basic_done_cycle got %0d want 72", n_done); end
    vectors++; if (widx !== 3) begin miscompares++; $display("FAIL basic_words got %0d want 3", widx); end
    vectors++; if (ce_cnt !== LEN) begin miscompares++; $display("FAIL basic_ce_cycles got %0d want %0d", ce_cnt, LEN); end
    vectors++; if (last_ce - first_ce + 1 !== LEN) begin miscompares++; $display("FAIL basic_contiguous got span %0d want %0d", last_ce - first_ce + 1, LEN); end
    bad = 0;
    for (int i = 0; i < LEN; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL basic_sin_stream got %0d bad bits want 0", bad); end
    vectors++; if (chain !== stream_of(32'hA5C3_0F96, 32'h1234_5678, 32'hDEAD_BE2D)) begin miscompares++; $display("FAIL basic_chain got %h want %h", chain, stream_of(32'hA5C3_0F96, 32'h1234_5678, 32'hDEAD_BE2D)); end
    vectors++; if (bit_cnt !== CW'(LEN)) begin miscompares++; $display("FAIL basic_bitcnt got %0d want %0d", bit_cnt, LEN); end
    vectors++; if (busy !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL basic_end_flags got busy=%b done=%b want 0/1", busy, done); end
  endtask

  task automatic test_starvation();
    int n_done, bad;
    begin_session(32'h0F0F_3C3C, 32'h8001_7FFE, 32'hFFFF_FF2A, 1'b1);
    run_to_done(300, -1, n_done);
    vectors++; if (n_done !== 77) begin miscompares++; $display("FAIL starve_done_cycle got %0d want 77", n_done); end
    vectors++; if (gap_cnt_q.size() !== 5) begin miscompares++; $display("FAIL starve_gap_len got %0d want 5", gap_cnt_q.size()); end
    bad = 0;
    foreach (gap_cnt_q[i]) if (gap_cnt_q[i] !== 32 || gap_sin_q[i] !== 1'b0) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL starve_gap_hold got %0d bad cycles want 0", bad); end
    vectors++; if (ce_cnt !== LEN) begin miscompares++; $display("FAIL starve_ce_cycles got %0d want %0d", ce_cnt, LEN); end
    bad = 0;
    for (int i = 0; i < LEN; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL starve_sin_stream got %0d bad bits want 0", bad); end
    vectors++; if (bit_cnt !== CW'(LEN)) begin miscompares++; $display("FAIL starve_bitcnt got %0d want %0d", bit_cnt, LEN); end
  endtask

  task automatic test_ignored();
    int n_done, bad;
    begin_session(32'h5555_AAAA, 32'h3333_CCCC, 32'hABCD_EF17, 1'b0);
    run_to_done(200, 20, n_done);
    vectors++; if (n_done !== 72) begin miscompares++; $display("FAIL ignore_done_cycle got %0d want 72", n_done); end
    vectors++; if (widx !== 3) begin miscompares++; $display("FAIL ignore_words got %0d want 3", widx); end
    bad = 0;
    foreach (late_ready_q[i]) if (late_ready_q[i] !== 1'b0) bad++;
    vectors++; if (bad !== 0 || late_ready_q.size() == 0) begin miscompares++; $display("FAIL ignore_late_ready got %0d high of %0d want 0", bad, late_ready_q.size()); end
    vectors++; if (bit_cnt !== CW'(LEN)) begin miscompares++; $display("FAIL ignore_bitcnt got %0d want %0d", bit_cnt, LEN); end
  endtask

  task automatic test_reset_mid();
    int n;
    begin_session(32'h1111_2222, 32'h4444_8888, 32'h0000_003F, 1'b0);
    for (n = 0; n < 200; n++) begin
      tick();
      if (bit_cnt == CW'(40)) break;
    end
    vectors++; if (busy !== 1'b1 || bit_cnt !== CW'(40)) begin miscompares++; $display("FAIL midrst_reach got busy=%b cnt=%0d want 1/40", busy, bit_cnt); end
    feed = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if ({s_ready, sin, ce, busy, done} !== 5'b0 || bit_cnt !== '0) begin miscompares++; $display("FAIL midrst_outputs got rdy=%b sin=%b ce=%b busy=%b done=%b cnt=%0d want all 0", s_ready, sin, ce, busy, done, bit_cnt); end
    tick(); tick();
    vectors++; if (ce !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle got ce=%b busy=%b want 0/0", ce, busy); end
  endtask

  task automatic test_chain();
    int n_done;
    logic [W-1:0] ra0, ra1, ra2;
    ra0 = 32'hCAFE_F00D; ra1 = 32'h0BAD_C0DE; ra2 = 32'h7777_7715;
    begin_session(ra0, ra1, ra2, 1'b0);
    run_to_done(200, -1, n_done);
    vectors++; if (chain !== stream_of(ra0, ra1, ra2)) begin miscompares++; $display("FAIL chain_a got %h want %h", chain, stream_of(ra0, ra1, ra2)); end
    begin_session(32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_FFEA, 1'b0);
    run_to_done(200, -1, n_done);
    vectors++; if (chain !== stream_of(32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_FFEA)) begin miscompares++; $display("FAIL chain_b got %h want %h", chain, stream_of(32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_FFEA)); end
`ifdef SCAN_READBACK_EN
    vectors++; if (rd_q.size() !== 3) begin miscompares++; $display("FAIL rb_pulses got %0d want 3", rd_q.size()); end
    if (rd_q.size() == 3) begin
      vectors++; if (rd_q[0] !== ra0) begin miscompares++; $display("FAIL rb_word0 got %h want %h", rd_q[0], ra0); end
      vectors++; if (rd_q[1] !== ra1) begin miscompares++; $display("FAIL rb_word1 got %h want %h", rd_q[1], ra1); end
      vectors++; if (rd_q[2] !== (ra2 & 32'h3F)) begin miscompares++; $display("FAIL rb_word2 got %h want %h", rd_q[2], ra2 & 32'h3F); end
    end
`endif
  endtask

  task automatic test_default();
    int n_done, acc, ces, rvs;
    n_done = -1; acc = 0; ces = 0; rvs = 0;
    b_valid = 1'b1; b_data = 32'h9E37_79B9; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (b_valid && b_ready) acc++;
      if (b_ce) ces++;
`ifdef SCAN_READBACK_EN
      if (b_rvalid) rvs++;
`endif
      if (b_done) begin
        n_done = n;
        break;
      end
      @(posedge clk); #1;
      b_data = b_data + 32'h0101_0101;
    end
    b_valid = 1'b0;
    vectors++; if (n_done !== 994) begin miscompares++; $display("FAIL big_done_cycle got %0d want 994", n_done); end
    vectors++; if (acc !== 31) begin miscompares++; $display("FAIL big_words got %0d want 31", acc); end
    vectors++; if (ces !== 992) begin miscompares++; $display("FAIL big_ce_cycles got %0d want 992", ces); end
    vectors++; if (b_bit_cnt !== BIG_CW'(992) || b_busy !== 1'b0 || b_sin !== 1'b0) begin miscompares++; $display("FAIL big_end got cnt=%0d busy=%b sin=%b want 992/0/0", b_bit_cnt, b_busy, b_sin); end
`ifdef SCAN_READBACK_EN
    vectors++; if (rvs !== 31 || b_rdata !== '0) begin miscompares++; $display("FAIL big_rb got %0d pulses data %h want 31/0", rvs, b_rdata); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; feed = 1'b0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    cyc = 0; widx = 0; exp_bits = 0; ce_cnt = 0; stall_left = 0; stall_armed = 1'b0; done_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_starvation();
    test_ignored();
    test_reset_mid();
    test_chain();
    test_default();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
